mips_avalon_arbiter: RTL and testbench

Shares the single Avalon memory master between the CPU's instruction-fetch port (read-only) and data port (read/write). Each CPU-side port is an Avalon slave with its own waitrequest. The arbiter grants one port at a time, forwards its transaction to the memory bus, and returns the completion. It sits between the CPU/cache controller and mips_avalon_slave.

---
 rtl/mips_avalon_arbiter.sv | 131 +++++++++++++
 tb/tb_mips_avalon_arbiter.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mips_avalon_arbiter.sv
// mips_avalon_arbiter: shares one Avalon memory master between the CPU
// instruction-fetch port (read-only) and the data port (read/write).
// Round-robin between the two ports when both request; one IDLE bubble
// separates consecutive transactions.
// Optional feature macro: ARB_TIMEOUT_EN (sticky stall-timeout flag).
module mips_avalon_arbiter #(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_address,
    input  logic        i_read,
    output logic        i_waitrequest,
    output logic [31:0] i_readdata,
    input  logic [31:0] d_address,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_writedata,
    input  logic [3:0]  d_byteenable,
    output logic        d_waitrequest,
    output logic [31:0] d_readdata,
    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteenable,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,
    output logic        timeout
);

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_D} state_t;

    localparam logic RR_I = 1'b0;
    localparam logic RR_D = 1'b1;

    state_t state, state_nx;
    logic   rr_last;    // port that completed most recently
    logic   pend_i, pend_d;
    logic   done_i, done_d;

    assign pend_i = i_read;
    assign pend_d = d_read | d_write;

    // State register and round-robin pointer; pointer moves on completion
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rr_last <= RR_I;
        end else begin
            state <= state_nx;
            if (done_i) rr_last <= RR_I;
            if (done_d) rr_last <= RR_D;
        end
    end

    // Next-state selection and memory-bus drive for the granted port
    always_comb begin
        state_nx       = state;
        mem_address    = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_writedata  = '0;
        mem_byteenable = '0;
        done_i         = 1'b0;
        done_d         = 1'b0;
        case (state)
            IDLE: begin
                if (pend_i && pend_d)
                    state_nx = (rr_last == RR_I) ? GNT_D : GNT_I;
                else if (pend_i)
                    state_nx = GNT_I;
                else if (pend_d)
                    state_nx = GNT_D;
            end
            GNT_I: begin
                mem_address    = i_address;
                mem_read       = 1'b1;
                mem_byteenable = 4'b1111;
                if (!mem_waitrequest) begin
                    done_i   = 1'b1;
                    state_nx = IDLE;
                end
            end
            GNT_D: begin
                mem_address    = d_address;
                // read+write together is illegal; the write wins
                mem_read       = d_read & ~d_write;
                mem_write      = d_write;
                mem_writedata  = d_writedata;
                mem_byteenable = d_byteenable;
                if (!mem_waitrequest) begin
                    done_d   = 1'b1;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // A requester stalls until the cycle its own transaction completes
    assign i_waitrequest = pend_i & ~done_i;
    assign d_waitrequest = pend_d & ~done_d;
    assign i_readdata    = done_i ? mem_readdata : 32'h0;
    assign d_readdata    = done_d ? mem_readdata : 32'h0;

`ifdef ARB_TIMEOUT_EN
    logic [31:0] stall_cnt;
    logic        timeout_q;

    // Count stalled granted cycles; flag is sticky until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            timeout_q <= 1'b0;
        end else if (state == IDLE && state_nx != IDLE) begin
            stall_cnt <= '0;
        end else if (state != IDLE && mem_waitrequest) begin
            if (stall_cnt != '1) stall_cnt <= stall_cnt + 32'd1;
            if (stall_cnt + 32'd1 >= 32'(TIMEOUT_CYCLES)) timeout_q <= 1'b1;
        end
    end

    assign timeout = timeout_q;
`else
    // Feature disabled: the flag is constant 0 (comparison is constant-false
    // for any legal TIMEOUT_CYCLES, keeping the parameter referenced).
    assign timeout = (TIMEOUT_CYCLES < 0);
`endif

endmodule

// File: tb/tb_mips_avalon_arbiter.sv
// Directed self-checking bench for mips_avalon_arbiter with a small
// behavioural Avalon memory slave of programmable wait-state count.
module tb_mips_avalon_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] i_address, i_readdata;
    logic        i_read, i_waitrequest;
    logic [31:0] d_address, d_writedata, d_readdata;
    logic        d_read, d_write, d_waitrequest;
    logic [3:0]  d_byteenable;
    logic [31:0] mem_address, mem_writedata, mem_readdata;
    logic        mem_read, mem_write, mem_waitrequest;
    logic [3:0]  mem_byteenable;
    logic        timeout;

    int checks = 0;
    int errors = 0;
    int delay = 0;
    int scnt = 0;
    int overlap = 0;
    logic [31:0] mem [16];

    // captured on the completion cycle by wait_done
    logic [31:0] cap_rd, cap_addr;
    logic [3:0]  cap_be;
    logic        cap_wr, cap_rdstb;

    always #5 clk = ~clk;

    mips_avalon_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst(rst),
        .i_address(i_address), .i_read(i_read),
        .i_waitrequest(i_waitrequest), .i_readdata(i_readdata),
        .d_address(d_address), .d_read(d_read), .d_write(d_write),
        .d_writedata(d_writedata), .d_byteenable(d_byteenable),
        .d_waitrequest(d_waitrequest), .d_readdata(d_readdata),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
        .mem_waitrequest(mem_waitrequest), .mem_readdata(mem_readdata),
        .timeout(timeout)
    );

    // Slave model: stalls 'delay' cycles per transaction, word-indexed memory
    assign mem_waitrequest = (mem_read | mem_write) && (scnt < delay);
    assign mem_readdata    = mem_read ? mem[mem_address[5:2]] : 32'h0;

    always @(posedge clk) begin
        if (rst) begin
            scnt <= 0;
            for (int j = 0; j < 16; j++) mem[j] <= 32'h1000_0000 + j;
            mem[0] <= 32'h3C1D_A000;
            mem[4] <= 32'h1234_5678;
        end else begin
            if ((mem_read | mem_write) && mem_waitrequest) scnt <= scnt + 1;
            else scnt <= 0;
            if (mem_write && !mem_waitrequest)
                for (int b = 0; b < 4; b++)
                    if (mem_byteenable[b])
                        mem[mem_address[5:2]][8*b +: 8] <= mem_writedata[8*b +: 8];
        end
    end

    always @(negedge clk) if (mem_read && mem_write) overlap <= overlap + 1;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    // Wait (bounded) for the selected port to complete; n = cycles after request
    task automatic wait_done(input bit is_d, output int n);
        bit done = 0;
        n = 0;
        while (!done && n < 40) begin
            @(negedge clk); #1; n++;
            if ((is_d ? d_waitrequest : i_waitrequest) == 1'b0) begin
                done      = 1;
                cap_rd    = is_d ? d_readdata : i_readdata;
                cap_addr  = mem_address;
                cap_be    = mem_byteenable;
                cap_wr    = mem_write;
                cap_rdstb = mem_read;
            end
        end
        if (!done) chk("wait_bound", 32'(n), 32'd0);
    endtask

    initial begin
        int n;
        bit gd;
        logic exp_to;
        rst = 1'b1;
        i_address = '0; i_read = 0;
        d_address = '0; d_read = 0; d_write = 0; d_writedata = '0; d_byteenable = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_read", 32'(mem_read), 0);
        chk("rst_mem_write", 32'(mem_write), 0);
        chk("rst_mem_addr", mem_address, 0);
        chk("rst_i_wait", 32'(i_waitrequest), 0);
        chk("rst_d_wait", 32'(d_waitrequest), 0);
        chk("rst_timeout", 32'(timeout), 0);
        @(negedge clk); rst = 1'b0;

        // Instruction fetch, 2 wait states: bus from cycle 1, done at cycle 3
        delay = 2;
        @(negedge clk); i_read = 1; i_address = 32'hBFC0_0000; #1;
        chk("if_c0_wait", 32'(i_waitrequest), 1);
        chk("if_c0_mem_read", 32'(mem_read), 0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk); #1;
            chk("if_mem_read", 32'(mem_read), 1);
            chk("if_mem_addr", mem_address, 32'hBFC0_0000);
            chk("if_mem_be", 32'(mem_byteenable), 4'hF);
            chk("if_i_wait", 32'(i_waitrequest), (k == 3) ? 0 : 1);
            chk("if_i_rdata", i_readdata, (k == 3) ? 32'h3C1D_A000 : 32'h0);
            chk("if_d_wait", 32'(d_waitrequest), 0);
        end
        @(negedge clk); i_read = 0; #1;
        chk("if_bubble_mem_read", 32'(mem_read), 0);
        chk("if_after_i_wait", 32'(i_waitrequest), 0);

        // Partial write then readback of the same word
        delay = 1;
        @(negedge clk);
        d_write = 1; d_address = 32'hBFC0_0010; d_writedata = 32'hDEAD_BEEF; d_byteenable = 4'b0011;
        #1; chk("wr_idle_wait", 32'(d_waitrequest), 1);
        wait_done(1, n);
        chk("wr_latency", 32'(n), 2);
        chk("wr_mem_write", 32'(cap_wr), 1);
        chk("wr_mem_read", 32'(cap_rdstb), 0);
        chk("wr_mem_be", 32'(cap_be), 4'b0011);
        chk("wr_mem_addr", cap_addr, 32'hBFC0_0010);
        @(negedge clk); d_write = 0; #1;
        chk("wr_after_wait", 32'(d_waitrequest), 0);
        @(negedge clk); d_read = 1; d_byteenable = 4'hF;
        wait_done(1, n);
        chk("rd_latency", 32'(n), 2);
        chk("rd_data", cap_rd, 32'h1234_BEEF);
        @(negedge clk); d_read = 0;
        chk("no_rw_overlap", 32'(overlap), 0);

        // Continuous contention after reset: D, I, D, I with IDLE bubbles
        do_reset();
        delay = 0;
        i_read = 1; i_address = 32'hBFC0_0004;
        d_read = 1; d_address = 32'hBFC0_0030;
        #1;
        chk("cont_c0_i_wait", 32'(i_waitrequest), 1);
        chk("cont_c0_d_wait", 32'(d_waitrequest), 1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk); #1;
            if (k % 2 == 0) begin
                chk("cont_idle_mem_read", 32'(mem_read), 0);
                chk("cont_idle_i_wait", 32'(i_waitrequest), 1);
                chk("cont_idle_d_wait", 32'(d_waitrequest), 1);
            end else begin
                gd = (k == 1 || k == 5);
                chk("cont_mem_read", 32'(mem_read), 1);
                chk("cont_mem_addr", mem_address, gd ? 32'hBFC0_0030 : 32'hBFC0_0004);
                chk("cont_d_wait", 32'(d_waitrequest), gd ? 0 : 1);
                chk("cont_i_wait", 32'(i_waitrequest), gd ? 1 : 0);
                chk("cont_d_rdata", d_readdata, gd ? 32'h1000_000C : 32'h0);
                chk("cont_i_rdata", i_readdata, gd ? 32'h0 : 32'h1000_0001);
            end
        end
        @(negedge clk); i_read = 0; d_read = 0;

        // Reset in the middle of a stalled data write
        delay = 20;
        @(negedge clk);
        d_write = 1; d_address = 32'hBFC0_0008; d_writedata = 32'hCAFE_F00D; d_byteenable = 4'hF;
        @(negedge clk); #1;
        chk("rstmid_mem_write", 32'(mem_write), 1);
        chk("rstmid_d_wait", 32'(d_waitrequest), 1);
        rst = 1;
        @(negedge clk); #1;
        chk("rstmid_idle_write", 32'(mem_write), 0);
        chk("rstmid_idle_addr", mem_address, 0);
        rst = 0; d_write = 0; #1;
        chk("rstmid_rel_d_wait", 32'(d_waitrequest), 0);
        @(negedge clk); #1;
        chk("rstmid_stay_idle", 32'(mem_write), 0);

        // Illegal read+write: treated as a write
        delay = 1;
        @(negedge clk);
        d_read = 1; d_write = 1; d_address = 32'hBFC0_0020; d_writedata = 32'h55AA_1234; d_byteenable = 4'hF;
        wait_done(1, n);
        chk("rw_mem_write", 32'(cap_wr), 1);
        chk("rw_mem_read", 32'(cap_rdstb), 0);
        @(negedge clk); d_write = 0;
        wait_done(1, n);
        chk("rw_readback", cap_rd, 32'h55AA_1234);
        @(negedge clk); d_read = 0;

        // Long stall: timeout after 8 stalled cycles (feature build only)
        delay = 20;
        @(negedge clk); i_read = 1; i_address = 32'hBFC0_0000;
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk); #1;
`ifdef ARB_TIMEOUT_EN
            exp_to = (k >= 9);
`else
            exp_to = 1'b0;
`endif
            chk("to_flag", 32'(timeout), 32'(exp_to));
            chk("to_i_wait", 32'(i_waitrequest), (k == 21) ? 0 : 1);
        end
        @(negedge clk); i_read = 0;
        repeat (2) @(negedge clk);
        #1;
        chk("to_sticky", 32'(timeout), 32'(exp_to));
        do_reset();
        #1; chk("to_cleared", 32'(timeout), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
